// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC/fetch unit.
package pc_fetch_pkg;

  typedef enum logic [2:0] {
    START   = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    FAULT   = 3'd4
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_TARGET = 2'd1,
    PC_ALU    = 2'd2
  } pc_src_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Next-PC mux: PC+4, branch/JAL target, JALR target, with alignment handling.
// With PC_FETCH_MISALIGN_TRAP_EN the raw target is passed through and flagged.
module next_pc_sel
  import pc_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcSrc,
  input  logic [31:0] pcTarget,
  input  logic [31:0] aluResult,
  output logic [31:0] pcPlus4,
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  output logic [31:0] nextPc
);

  logic [31:0] rawNext;

  assign pcPlus4 = pc + 32'd4;

  // Encoding 3 is reserved and behaves like sequential fetch.
  always_comb begin
    rawNext = pcPlus4;
    case (pcSrc)
      PC_TARGET: rawNext = pcTarget;
      PC_ALU:    rawNext = aluResult & ~32'd1;
      default:   rawNext = pcPlus4;
    endcase
  end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  assign misaligned = |rawNext[1:0];
  assign nextPc     = rawNext;
`else
  assign nextPc     = rawNext & ~32'd3;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner and single-outstanding instruction fetcher.
// Optional misaligned-target trap: PC_FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] FLUSH_VECTOR = 32'h0000_0100,
  parameter logic [31:0] NOP_INSTR    = pc_fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [1:0]  pcSrc,
  input  logic [31:0] pcTarget,
  input  logic [31:0] aluResult,
  input  logic        flush,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemValid,
  input  logic [31:0] imemRdata,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        fetchFault,
  output logic [2:0]  fsmState
);
  import pc_fetch_pkg::*;

  // Handshakes: imem transfers a request on imemReq && imemGnt and returns
  // exactly one response on imemValid; decode takes instr on instrValid && instrReady.

  fetch_state_t state, stateNext;
  logic [31:0]  pcNext, instrNext, nextPc;
  logic         dropPending, dropNext;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic faultQ, faultNext, misaligned;
  assign fetchFault = faultQ;
`else
  assign fetchFault = 1'b0;
`endif

  next_pc_sel uNextPcSel (
    .pc        (pc),
    .pcSrc     (pcSrc),
    .pcTarget  (pcTarget),
    .aluResult (aluResult),
    .pcPlus4   (pcPlus4),
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    .misaligned(misaligned),
`endif
    .nextPc    (nextPc)
  );

  assign imemReq    = (state == REQ);
  assign imemAddr   = pc;
  assign instrValid = (state == DELIVER);
  assign fsmState   = state;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= START;
      pc          <= RESET_VECTOR;
      instr       <= NOP_INSTR;
      dropPending <= 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      faultQ      <= 1'b0;
`endif
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      instr       <= instrNext;
      dropPending <= dropNext;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      faultQ      <= faultNext;
`endif
    end
  end

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    instrNext = instr;
    dropNext  = dropPending;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    faultNext = faultQ;
`endif
    if (flush) begin
      pcNext    = FLUSH_VECTOR;
      instrNext = NOP_INSTR;
      stateNext = REQ;
      dropNext  = 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      faultNext = 1'b0;
`endif
      // A fetch still in flight must have its response swallowed.
      if ((state == WAIT && !imemValid) || (state == REQ && imemGnt)) begin
        dropNext  = 1'b1;
        stateNext = WAIT;
      end
    end else begin
      case (state)
        START: stateNext = REQ;
        REQ: begin
          if (imemGnt) stateNext = WAIT;
        end
        WAIT: begin
          if (imemValid) begin
            if (dropPending) begin
              dropNext  = 1'b0;
              stateNext = REQ;
            end else begin
              instrNext = imemRdata;
              stateNext = DELIVER;
            end
          end
        end
        DELIVER: begin
          if (instrReady) begin
            pcNext    = nextPc;
            instrNext = NOP_INSTR;
            stateNext = REQ;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
              faultNext = 1'b1;
              stateNext = FAULT;
            end
`endif
          end
        end
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        FAULT: stateNext = FAULT;
`endif
        default: stateNext = START;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector table plus corner-case sequences.
module tb_pc_fetch_unit;
  import pc_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [1:0]  pcSrc = 2'd0;
  logic [31:0] pcTarget = '0;
  logic [31:0] aluResult = '0;
  logic        flush = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt = 1'b0;
  logic        imemValid = 1'b0;
  logic [31:0] imemRdata = '0;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        fetchFault;
  logic [2:0]  fsmState;

  pc_fetch_unit dut (
    .clk(clk), .rstN(rstN), .pcSrc(pcSrc), .pcTarget(pcTarget),
    .aluResult(aluResult), .flush(flush), .imemReq(imemReq),
    .imemAddr(imemAddr), .imemGnt(imemGnt), .imemValid(imemValid),
    .imemRdata(imemRdata), .instrValid(instrValid), .instrReady(instrReady),
    .instr(instr), .pc(pc), .pcPlus4(pcPlus4), .fetchFault(fetchFault),
    .fsmState(fsmState)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] expPc = 32'h0;

  typedef struct {
    int          gntDelay;
    logic [31:0] rdata;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] alu;
    logic [31:0] expNext;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks (all entered and left on a negedge)
  task automatic wait_req();
    int n = 0;
    while (!imemReq && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, imemReq}, 32'd1);
  endtask

  task automatic do_fetch(input int gntDelay, input logic [31:0] data);
    wait_req();
    check("fetch_addr", imemAddr, expPc);
    for (int i = 0; i < gntDelay; i++) begin
      imemGnt = 1'b0;
      @(negedge clk);
      check("req_held", {31'd0, imemReq}, 32'd1);
      check("addr_held", imemAddr, expPc);
    end
    imemGnt = 1'b1;
    @(negedge clk);
    imemGnt = 1'b0;
    check("req_low_in_wait", {31'd0, imemReq}, 32'd0);
    imemValid = 1'b1;
    imemRdata = data;
    exp_q.push_back(data);
    @(negedge clk);
    imemValid = 1'b0;
    imemRdata = $urandom;
  endtask

  task automatic wait_valid_and_pop();
    int n = 0;
    while (!instrValid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("instr_valid", {31'd0, instrValid}, 32'd1);
    if (exp_q.size() == 0) begin
      check("exp_q_nonempty", 32'd0, 32'd1);
    end else begin
      check("instr", instr, exp_q.pop_front());
    end
  endtask

  task automatic do_deliver(input logic [1:0] src, input logic [31:0] tgt,
                            input logic [31:0] alu, input logic [31:0] expNext);
    logic [31:0] held;
    int stall;
    wait_valid_and_pop();
    held = instr;
    stall = $urandom_range(0, 2);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("instr_stable", instr, held);
      check("valid_stable", {31'd0, instrValid}, 32'd1);
    end
    pcSrc = src; pcTarget = tgt; aluResult = alu;
    instrReady = 1'b1;
    @(negedge clk);
    instrReady = 1'b0;
    pcSrc = $urandom_range(0, 3); pcTarget = $urandom; aluResult = $urandom;
    expPc = expNext;
    check("pc_next", pc, expPc);
    check("valid_cleared", {31'd0, instrValid}, 32'd0);
    check("instr_nop", instr, NOP);
  endtask

  initial begin
    vecs[0] = '{0, 32'h0050_0093, 2'd0, 32'h0,         32'h0,         32'h0000_0004};
    vecs[1] = '{2, 32'h0010_0113, 2'd0, 32'h0,         32'h0,         32'h0000_0008};
    vecs[2] = '{0, 32'h0000_0067, 2'd2, 32'h0,         32'h0000_0045, 32'h0000_0044};
    vecs[3] = '{5, 32'h1F00_006F, 2'd1, 32'h0000_0200, 32'h0,         32'h0000_0200};
    vecs[4] = '{1, 32'h0020_8233, 2'd3, 32'h0000_0FF0, 32'h0000_0FF0, 32'h0000_0204};
    vecs[5] = '{0, 32'h0000_0063, 2'd1, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC};
    vecs[6] = '{0, 32'h0030_0193, 2'd0, 32'h0,         32'h0,         32'h0000_0000};
    vecs[7] = '{0, 32'h0000_0663, 2'd1, 32'h0000_000C, 32'h0,         32'h0000_000C};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imemReq}, 32'd0);
    check("rst_valid", {31'd0, instrValid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc, 32'h0);
    check("rst_pcplus4", pcPlus4, 32'h4);
    check("rst_fault", {31'd0, fetchFault}, 32'd0);
    check("rst_state", {29'd0, fsmState}, {29'd0, START});
    rstN = 1'b1;
    @(negedge clk);
    check("req_after_release", {31'd0, imemReq}, 32'd1);

    // table-driven fetch/retire vectors
    for (int v = 0; v < 8; v++) begin
      do_fetch(vecs[v].gntDelay, vecs[v].rdata);
      do_deliver(vecs[v].src, vecs[v].tgt, vecs[v].alu, vecs[v].expNext);
    end

    // misaligned branch target from pc=12
    do_fetch(0, 32'h0000_0563);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    do_deliver(2'd1, 32'h0000_0016, 32'h0, 32'h0000_0016);
    check("trap_fault", {31'd0, fetchFault}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("trap_no_req", {31'd0, imemReq}, 32'd0);
      check("trap_fault_sticky", {31'd0, fetchFault}, 32'd1);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    expPc = 32'h100;
    check("trap_flush_clear", {31'd0, fetchFault}, 32'd0);
    check("trap_flush_pc", pc, expPc);
`else
    do_deliver(2'd1, 32'h0000_0016, 32'h0, 32'h0000_0014);
    check("no_trap_fault", {31'd0, fetchFault}, 32'd0);
`endif

    // flush while waiting, stale data arrives next cycle
    wait_req();
    check("flushwait_addr", imemAddr, expPc);
    imemGnt = 1'b1;
    @(negedge clk);
    imemGnt = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    expPc = 32'h100;
    check("flushwait_pc", pc, expPc);
    imemValid = 1'b1;
    imemRdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imemValid = 1'b0;
    check("stale_not_valid", {31'd0, instrValid}, 32'd0);
    check("stale_refetch_addr", imemAddr, 32'h100);
    do_fetch(0, 32'h0040_0213);
    do_deliver(2'd0, 32'h0, 32'h0, 32'h104);

    // flush in REQ coinciding with grant: that grant's response is dropped
    wait_req();
    imemGnt = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    imemGnt = 1'b0;
    flush = 1'b0;
    expPc = 32'h100;
    check("flushgnt_wait", {31'd0, imemReq}, 32'd0);
    imemValid = 1'b1;
    imemRdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imemValid = 1'b0;
    check("flushgnt_not_valid", {31'd0, instrValid}, 32'd0);
    check("flushgnt_req", {31'd0, imemReq}, 32'd1);
    check("flushgnt_addr", imemAddr, expPc);

    // flush in WAIT with data arriving the same cycle: nothing left to drop
    imemGnt = 1'b1;
    @(negedge clk);
    imemGnt = 1'b0;
    flush = 1'b1;
    imemValid = 1'b1;
    imemRdata = 32'hDEAD_BEEF;
    @(negedge clk);
    flush = 1'b0;
    imemValid = 1'b0;
    check("flushval_not_valid", {31'd0, instrValid}, 32'd0);
    check("flushval_req", {31'd0, imemReq}, 32'd1);
    do_fetch(0, 32'h0050_0293);
    do_deliver(2'd0, 32'h0, 32'h0, 32'h104);

    // flush beats instrReady in DELIVER
    do_fetch(0, 32'h0060_0313);
    wait_valid_and_pop();
    instrReady = 1'b1; pcSrc = 2'd1; pcTarget = 32'h300; flush = 1'b1;
    @(negedge clk);
    instrReady = 1'b0; flush = 1'b0;
    expPc = 32'h100;
    check("flushdlv_pc", pc, expPc);
    check("flushdlv_valid", {31'd0, instrValid}, 32'd0);
    check("flushdlv_instr", instr, NOP);

    // asynchronous reset during DELIVER
    do_fetch(1, 32'h0070_0393);
    wait_valid_and_pop();
    #1 rstN = 1'b0;
    #1;
    check("arst_valid", {31'd0, instrValid}, 32'd0);
    check("arst_pc", pc, 32'h0);
    check("arst_instr", instr, NOP);
    @(negedge clk);
    rstN = 1'b1;
    expPc = 32'h0;
    do_fetch(0, 32'h0080_0413);
    do_deliver(2'd0, 32'h0, 32'h0, 32'h4);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
